// File: rtl/flippy_pkg.sv
// -----------------------------------------------------------------------------
// flippy_pkg
// Shared definitions for the falling-byte game lane:
//   - lane FSM state encoding (plain logic constants so older code that
//     compares raw state vectors keeps working)
//   - default timing parameters for a 50 MHz board clock
//   - LFSR tap constant and the single-step LFSR helper
// No ports; imported with "import flippy_pkg::*;".
// -----------------------------------------------------------------------------
package flippy_pkg;

  // Lane FSM state encoding.
  localparam int         STATE_W       = 3;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SPAWN_WAIT = 3'd1;
  localparam logic [2:0] ST_FALLING    = 3'd2;
  localparam logic [2:0] ST_HIT        = 3'd3;
  localparam logic [2:0] ST_OVER       = 3'd4;

  // Defaults: half a second per row and a quarter second between bytes
  // at 50 MHz.
  localparam int unsigned DEF_DROP_PERIOD = 25000000;
  localparam int unsigned DEF_ROWS        = 8;
  localparam int unsigned DEF_SPAWN_DELAY = 12500000;
  localparam logic [7:0]  DEF_LFSR_SEED   = 8'hA5;

  // x^8 + x^6 + x^5 + x^4 + 1, right-shifting Galois form (maximal length).
  localparam logic [7:0]  LFSR_TAPS       = 8'hB8;

  // Flipping the top bit of a spawned byte guarantees it differs from the
  // switches the player is already holding.
  localparam logic [7:0]  SPAWN_FLIP      = 8'h80;

  // One Galois step. The map is invertible and fixes only zero, so a
  // nonzero register never reaches zero.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    logic [7:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// Free-running 8-bit Galois LFSR used as the byte generator for the lane.
// It advances on every rising clock edge whenever reset is low, regardless
// of what the game is doing, so the spawned byte depends on player timing.
//
// Parameters:
//   SEED   nonzero value loaded by reset
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-high; loads SEED
//   value  out  current LFSR contents (never zero for a nonzero SEED)
// -----------------------------------------------------------------------------
module lfsr8
  import flippy_pkg::*;
#(
  parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = lfsr_step(value_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/falling_byte_lane.sv
// -----------------------------------------------------------------------------
// falling_byte_lane
// One lane of the "catch the falling byte" game. After a spawn delay a
// pseudo-random byte appears at row 0 and steps down one row every
// DROP_PERIOD clocks. Setting the switches equal to the byte scores a hit
// (one-cycle correct pulse) and schedules the next byte; letting it expire
// on the last row ends the game until the game controller clears it.
//
// Parameters:
//   DROP_PERIOD  clocks per row step (>= 2)
//   ROWS         rows before the floor (2..16)
//   SPAWN_DELAY  clocks between start/hit and the next spawn (>= 1)
//   LFSR_SEED    nonzero LFSR reset value
// Ports:
//   clock         in   system clock, rising edge
//   reset_button  in   asynchronous, active-high board reset
//   reset_signal  in   synchronous clear, held high while the game is in
//                      its start state
//   switches      in   [7:0] player switches, already synchronised
//   target        out  [7:0] falling byte, 0 when nothing is falling
//   row           out  [3:0] row of the falling byte, 0 = top
//   active        out  high while a byte is falling
//   correct       out  one-cycle pulse on a hit
//   game_over     out  high from floor impact until cleared
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module falling_byte_lane
  import flippy_pkg::*;
#(
  parameter int unsigned DROP_PERIOD = DEF_DROP_PERIOD,
  parameter int unsigned ROWS        = DEF_ROWS,
  parameter int unsigned SPAWN_DELAY = DEF_SPAWN_DELAY,
  parameter logic [7:0]  LFSR_SEED   = DEF_LFSR_SEED
) (
  input  logic       clock,
  input  logic       reset_button,
  input  logic       reset_signal,
  input  logic [7:0] switches,
  output logic [7:0] target,
  output logic [3:0] row,
  output logic       active,
  output logic       correct,
  output logic       game_over
);

  // Counters only ever hold PERIOD-1 down to 0, so $clog2 bits suffice.
  // The guard keeps a degenerate one-cycle spawn delay at one bit wide.
  localparam int DROP_W  = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;
  localparam int SPAWN_W = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;

  localparam logic [DROP_W-1:0]  DROP_LAST  = DROP_W'(DROP_PERIOD - 1);
  localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_DELAY - 1);
  localparam logic [3:0]         ROW_LAST   = 4'(ROWS - 1);

  logic [STATE_W-1:0] state_q,     state_d;
  logic [DROP_W-1:0]  drop_cnt_q,  drop_cnt_d;
  logic [SPAWN_W-1:0] spawn_cnt_q, spawn_cnt_d;
  logic [7:0]         target_q,    target_d;
  logic [3:0]         row_q,       row_d;
  logic               active_q,    active_d;
  logic               correct_q,   correct_d;
  logic               game_over_q, game_over_d;

  logic [7:0]         lfsr_val;
  logic [7:0]         spawn_byte;
  logic               match;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset_button),
    .value (lfsr_val)
  );

  // A byte identical to the switches at spawn would score instantly, so
  // it is flipped in the top bit instead.
  always_comb begin
    spawn_byte = lfsr_val;
    if (lfsr_val == switches) begin
      spawn_byte = lfsr_val ^ SPAWN_FLIP;
    end
  end

  assign match = (switches == target_q);

  always_comb begin
    state_d     = state_q;
    drop_cnt_d  = drop_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    target_d    = target_q;
    row_d       = row_q;
    active_d    = active_q;
    correct_d   = 1'b0;
    game_over_d = game_over_q;

    if (reset_signal) begin
      // Game controller clear beats everything, including a same-cycle hit
      // or floor impact, so no stray correct/game_over escapes.
      state_d     = ST_IDLE;
      drop_cnt_d  = '0;
      spawn_cnt_d = '0;
      target_d    = 8'h00;
      row_d       = 4'd0;
      active_d    = 1'b0;
      game_over_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_SPAWN_WAIT;
          spawn_cnt_d = SPAWN_LAST;
        end

        ST_SPAWN_WAIT: begin
          if (spawn_cnt_q == '0) begin
            state_d    = ST_FALLING;
            target_d   = spawn_byte;
            row_d      = 4'd0;
            drop_cnt_d = DROP_LAST;
            active_d   = 1'b1;
          end else begin
            spawn_cnt_d = spawn_cnt_q - 1'b1;
          end
        end

        ST_FALLING: begin
          // A match wins over a same-cycle floor impact.
          if (match) begin
            state_d    = ST_HIT;
            correct_d  = 1'b1;
            active_d   = 1'b0;
            target_d   = 8'h00;
            row_d      = 4'd0;
            drop_cnt_d = '0;
          end else if ((drop_cnt_q == '0) && (row_q == ROW_LAST)) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
            active_d    = 1'b0;
            target_d    = 8'h00;
            drop_cnt_d  = '0;
          end else if (drop_cnt_q == '0) begin
            row_d      = row_q + 4'd1;
            drop_cnt_d = DROP_LAST;
          end else begin
            drop_cnt_d = drop_cnt_q - 1'b1;
          end
        end

        ST_HIT: begin
          state_d     = ST_SPAWN_WAIT;
          spawn_cnt_d = SPAWN_LAST;
        end

        ST_OVER: begin
          // Parked on the floor row until the controller clears the game.
          row_d = ROW_LAST;
        end

        default: begin
          state_d     = ST_IDLE;
          drop_cnt_d  = '0;
          spawn_cnt_d = '0;
          target_d    = 8'h00;
          row_d       = 4'd0;
          active_d    = 1'b0;
          game_over_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button) begin
      state_q     <= ST_IDLE;
      drop_cnt_q  <= '0;
      spawn_cnt_q <= '0;
      target_q    <= 8'h00;
      row_q       <= 4'd0;
      active_q    <= 1'b0;
      correct_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_cnt_q  <= drop_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
      target_q    <= target_d;
      row_q       <= row_d;
      active_q    <= active_d;
      correct_q   <= correct_d;
      game_over_q <= game_over_d;
    end
  end

  assign target    = target_q;
  assign row       = row_q;
  assign active    = active_q;
  assign correct   = correct_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_falling_byte_lane.sv
// -----------------------------------------------------------------------------
// tb_falling_byte_lane
// Directed scenarios followed by randomized play against a behavioural
// model that tracks the game as "which phase, how many cycles elapsed".
// -----------------------------------------------------------------------------
module tb_falling_byte_lane;

  localparam int         DP   = 4;
  localparam int         NR   = 8;
  localparam int         SD   = 2;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clock = 1'b0;
  logic       reset_button;
  logic       reset_signal;
  logic [7:0] switches;
  logic [7:0] target;
  logic [3:0] row;
  logic       active;
  logic       correct;
  logic       game_over;

  falling_byte_lane #(
    .DROP_PERIOD (DP),
    .ROWS        (NR),
    .SPAWN_DELAY (SD),
    .LFSR_SEED   (SEED)
  ) dut (
    .clock        (clock),
    .reset_button (reset_button),
    .reset_signal (reset_signal),
    .switches     (switches),
    .target       (target),
    .row          (row),
    .active       (active),
    .correct      (correct),
    .game_over    (game_over)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_FALL = 2;
  localparam int M_HIT  = 3;
  localparam int M_OVER = 4;

  int         m_mode;
  int         m_wait;   // spawn-wait cycles still to spend
  int         m_k;      // FALLING cycles already spent by this byte
  logic [7:0] m_tgt;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] galois(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_wait = 0;
    m_k    = 0;
    m_tgt  = 8'h00;
    m_lfsr = SEED;
  endtask

  task automatic model_step(input logic rs, input logic [7:0] sw);
    if (rs) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: begin m_mode = M_WAIT; m_wait = SD; end
        M_WAIT: begin
          m_wait--;
          if (m_wait == 0) begin
            m_mode = M_FALL;
            m_k    = 0;
            m_tgt  = (m_lfsr == sw) ? (m_lfsr ^ 8'h80) : m_lfsr;
          end
        end
        M_FALL: begin
          if (sw == m_tgt)            m_mode = M_HIT;
          else if (m_k == NR*DP - 1)  m_mode = M_OVER;
          else                        m_k++;
        end
        M_HIT: begin m_mode = M_WAIT; m_wait = SD; end
        default: ;
      endcase
    end
    m_lfsr = galois(m_lfsr);
  endtask

  task automatic check_outputs(input string where);
    int erow;
    erow = (m_mode == M_FALL) ? (m_k / DP) : ((m_mode == M_OVER) ? NR - 1 : 0);
    check_val({where, ".target"},    32'(target),    32'((m_mode == M_FALL) ? m_tgt : 8'h00));
    check_val({where, ".row"},       32'(row),       32'(erow));
    check_val({where, ".active"},    32'(active),    32'(m_mode == M_FALL));
    check_val({where, ".correct"},   32'(correct),   32'(m_mode == M_HIT));
    check_val({where, ".game_over"}, 32'(game_over), 32'(m_mode == M_OVER));
  endtask

  // Drive at the falling edge, let the rising edge act, check at the next
  // falling edge.
  task automatic cycle(input logic rs, input logic [7:0] sw);
    reset_signal = rs;
    switches     = sw;
    @(posedge clock);
    model_step(rs, sw);
    @(negedge clock);
    cyc++;
    check_outputs("cyc");
  endtask

  task automatic button_pulse();
    #2 reset_button = 1'b1;
    #1 model_reset();
    check_outputs("async_rst");
    @(negedge clock);
    reset_button = 1'b0;
    check_outputs("rst_held");
  endtask

  initial begin
    int         n;
    int         r;
    logic       rs;
    logic [7:0] sw;
    logic [7:0] hold_sw;
    logic [7:0] v;

    reset_button = 1'b1;
    reset_signal = 1'b1;
    switches     = 8'h00;
    model_reset();
    @(negedge clock);
    check_outputs("reset");
    reset_button = 1'b0;

    // Start-up: idle, then spawn latency.
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'h00);
    n = 0;
    do begin cycle(1'b0, 8'h00); n++; end while (!active && n < 10);
    check_val("spawn_latency", 32'(n), 32'd3);
    check_val("spawn_target_nonzero", 32'(target != 8'h00), 32'd1);
    check_val("spawn_row", 32'(row), 32'd0);

    // Untouched byte hits the floor after ROWS*DROP_PERIOD cycles.
    n = 0;
    do begin cycle(1'b0, 8'h00); n++; end while (!game_over && n < 100);
    check_val("fall_cycles", 32'(n), 32'(NR * DP));
    check_val("over_row", 32'(row), 32'(NR - 1));
    repeat (4) cycle(1'b0, 8'h00);
    check_val("over_hold", 32'(game_over), 32'd1);
    cycle(1'b1, 8'h00);
    check_val("over_clear", 32'(game_over), 32'd0);
    check_val("over_clear_row", 32'(row), 32'd0);

    // Hit at row 3.
    n = 0;
    do begin cycle(1'b0, 8'h00); n++; end while (!active && n < 10);
    n = 0;
    while (m_k < 3 * DP && n < 100) begin cycle(1'b0, ~m_tgt); n++; end
    check_val("pre_hit_row", 32'(row), 32'd3);
    v = m_tgt;
    cycle(1'b0, v);
    check_val("hit_correct", 32'(correct), 32'd1);
    check_val("hit_active", 32'(active), 32'd0);
    check_val("hit_target", 32'(target), 32'd0);
    cycle(1'b0, v);
    check_val("hit_pulse_width", 32'(correct), 32'd0);
    n = 0;
    do begin cycle(1'b0, v); n++; end while (!active && n < 10);
    check_val("respawn_latency", 32'(n), 32'd2);
    check_val("respawn_row", 32'(row), 32'd0);

    // Match on the very last cycle of the last row.
    n = 0;
    while (!(m_mode == M_FALL && m_k == NR * DP - 1) && n < 100) begin
      cycle(1'b0, ~m_tgt); n++;
    end
    cycle(1'b0, m_tgt);
    check_val("late_hit_correct", 32'(correct), 32'd1);
    check_val("late_hit_game_over", 32'(game_over), 32'd0);
    cycle(1'b0, 8'h00);
    check_val("late_hit_no_over", 32'(game_over), 32'd0);

    // Switches equal to the LFSR on the spawn cycle.
    n = 0;
    while (!(m_mode == M_WAIT && m_wait == 1) && n < 20) begin cycle(1'b0, 8'h00); n++; end
    v = m_lfsr;
    cycle(1'b0, v);
    check_val("collide_target", 32'(target), 32'(v ^ 8'h80));
    check_val("collide_active", 32'(active), 32'd1);
    cycle(1'b0, v);
    check_val("collide_no_correct", 32'(correct), 32'd0);

    // Controller clear mid-fall at row 5, even with matching switches.
    n = 0;
    while (!(m_mode == M_FALL && m_k == 5 * DP + 1) && n < 100) begin cycle(1'b0, ~m_tgt); n++; end
    check_val("pre_clear_row", 32'(row), 32'd5);
    cycle(1'b1, m_tgt);
    check_val("clear_active", 32'(active), 32'd0);
    check_val("clear_target", 32'(target), 32'd0);
    check_val("clear_row", 32'(row), 32'd0);
    check_val("clear_correct", 32'(correct), 32'd0);
    check_val("clear_game_over", 32'(game_over), 32'd0);

    // Board reset mid-fall clears without waiting for a clock.
    n = 0;
    while (!(m_mode == M_FALL && m_k == 2 * DP) && n < 100) begin cycle(1'b0, 8'h00); n++; end
    check_val("pre_button_active", 32'(active), 32'd1);
    button_pulse();

    // Randomized play.
    hold_sw = 8'h3C;
    repeat (1500) begin
      r  = int'($urandom_range(0, 999));
      rs = 1'b0;
      sw = hold_sw;
      if (r < 5 || (m_mode == M_OVER && r < 60)) begin
        rs = 1'b1;
      end else if (m_mode == M_FALL && r < 25) begin
        sw = m_tgt;
      end else if (m_mode == M_WAIT && m_wait == 1 && r < 400) begin
        sw = m_lfsr;
      end else if (r < 100) begin
        hold_sw = 8'($urandom);
        sw      = hold_sw;
      end
      cycle(rs, sw);
      if (r >= 997) begin
        button_pulse();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
